// File: rtl/fetch_unit_if.sv
// fetch_unit_if: memory read bus between the instruction fetch unit and memory.
//   memAddr  16  read address            (fetch -> memory)
//   memRd     1  read strobe, held while a request is outstanding
//   memRdy    1  response valid; memData is valid while high (memory -> fetch)
//   memData  16  read data
interface fetch_unit_if;
  logic [15:0] memAddr;
  logic        memRd;
  logic        memRdy;
  logic [15:0] memData;

  modport master (
    output memAddr,
    output memRd,
    input  memRdy,
    input  memData
  );

  modport slave (
    input  memAddr,
    input  memRd,
    output memRdy,
    output memData
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer (IDLE -> BUS -> DONE).
// A start seen in IDLE latches PCOut, then a memory read is held until memRdy
// or until TIMEOUT bus cycles pass without a response (sticky err).
// Ports:
//   clk      clock, all state changes on rising edge
//   rst      asynchronous active-low reset
//   start    fetch request, only looked at in IDLE
//   PCOut    address of the instruction to fetch
//   bus      memory read bus (master side: memAddr, memRd out; memRdy, memData in)
//   IR       instruction register, last successfully fetched word
//   ldPC     one-cycle pulse: PC block loads PC+1
//   done     one-cycle pulse: IR was updated by this fetch
//   busy     high whenever not IDLE
//   err      sticky timeout flag, cleared by the next accepted start
module fetch_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [15:0]  PCOut,
  fetch_unit_if.master bus,
  output logic [15:0]  IR,
  output logic         ldPC,
  output logic         done,
  output logic         busy,
  output logic         err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } state_t;

  state_t           state;
  logic [15:0]      addr_reg;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      ir_reg;
  logic             rd_reg;
  logic             ldpc_reg;
  logic             done_reg;
  logic             busy_reg;
  logic             err_reg;

  // Outputs are registered alongside the state so they carry no path from
  // inputs and all fall together on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      addr_reg <= '0;
      cnt      <= '0;
      ir_reg   <= '0;
      rd_reg   <= 1'b0;
      ldpc_reg <= 1'b0;
      done_reg <= 1'b0;
      busy_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            addr_reg <= PCOut;
            cnt      <= '0;
            err_reg  <= 1'b0;
            rd_reg   <= 1'b1;
            busy_reg <= 1'b1;
            state    <= BUS;
          end
        end
        BUS: begin
          // A response on the last allowed cycle still counts as success.
          if (bus.memRdy) begin
            ir_reg   <= bus.memData;
            rd_reg   <= 1'b0;
            ldpc_reg <= 1'b1;
            done_reg <= 1'b1;
            state    <= DONE;
          end else if (cnt == CNT_LAST) begin
            err_reg  <= 1'b1;
            rd_reg   <= 1'b0;
            busy_reg <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          ldpc_reg <= 1'b0;
          done_reg <= 1'b0;
          busy_reg <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          rd_reg   <= 1'b0;
          ldpc_reg <= 1'b0;
          done_reg <= 1'b0;
          busy_reg <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.memAddr = addr_reg;
  assign bus.memRd   = rd_reg;
  assign IR          = ir_reg;
  assign ldPC        = ldpc_reg;
  assign done        = done_reg;
  assign busy        = busy_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int TO = 16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] PCOut;
  logic [15:0] IR;
  logic        ldPC;
  logic        done;
  logic        busy;
  logic        err;

  fetch_unit_if bus ();

  fetch_unit #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .PCOut (PCOut),
    .bus   (bus),
    .IR    (IR),
    .ldPC  (ldPC),
    .done  (done),
    .busy  (busy),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: what a fetch unit must hold after each transaction.
  logic [15:0] model_ir  = 16'h0000;
  logic        model_err = 1'b0;

  // One complete fetch. The memory answers after `waits` empty bus cycles;
  // waits >= TO means it never answers. Caller guarantees the unit is IDLE.
  task automatic do_fetch(input logic [15:0] pc, input int waits, input logic [15:0] data,
                          input bit wiggle_pc, input bit hold_start);
    int n;
    int exp_n;
    bit success;
    success = (waits < TO);
    exp_n   = success ? waits + 1 : TO;
    start = 1'b1;
    PCOut = pc;
    bus.memRdy  = 1'($urandom_range(0, 1));
    bus.memData = 16'($urandom);
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_clear_on_start: err=%b required 0", err);
    end
    n = 0;
    while (bus.memRd === 1'b1 && n < TO + 4) begin
      checks++;
      if (bus.memAddr !== pc || busy !== 1'b1 || done !== 1'b0 || ldPC !== 1'b0) begin
        errors++;
        $display("FAIL bus_cycle%0d: addr=%h busy=%b done=%b ldPC=%b required addr=%h busy=1 done=0 ldPC=0",
                 n, bus.memAddr, busy, done, ldPC, pc);
      end
      if (wiggle_pc) PCOut = (n == 1) ? 16'hFFFF : 16'($urandom);
      bus.memRdy  = (n == waits);
      bus.memData = (n == waits) ? data : 16'($urandom);
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != exp_n) begin
      errors++; $display("FAIL memrd_cycles: got %0d required %0d", n, exp_n);
    end
    if (success) model_ir = data;
    model_err = !success;
    checks++;
    if (done !== success || ldPC !== success || err !== model_err || IR !== model_ir) begin
      errors++;
      $display("FAIL fetch_end: done=%b ldPC=%b err=%b IR=%h required done=%b ldPC=%b err=%b IR=%h",
               done, ldPC, err, IR, success, success, model_err, model_ir);
    end
    // Responses outside BUS must not reach IR.
    bus.memRdy  = 1'b1;
    bus.memData = ~data;
    if (success) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || ldPC !== 1'b0 || busy !== 1'b0 || IR !== model_ir) begin
        errors++;
        $display("FAIL done_pulse_end: done=%b ldPC=%b busy=%b IR=%h required 0 0 0 %h",
                 done, ldPC, busy, IR, model_ir);
      end
    end else begin
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL timeout_idle: busy=%b required 0", busy);
      end
    end
    bus.memRdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; PCOut = 16'h5A5A;
    bus.memRdy = 1'b1; bus.memData = 16'hDEAD;
    #12;
    checks++;
    if (IR !== 16'h0 || bus.memAddr !== 16'h0 || bus.memRd !== 1'b0 || ldPC !== 1'b0 ||
        done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: IR=%h addr=%h rd=%b ldPC=%b done=%b busy=%b err=%b required all 0",
               IR, bus.memAddr, bus.memRd, ldPC, done, busy, err);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.memRdy = 1'b0;
  endtask

  task automatic test_zero_wait();
    do_fetch(16'h3000, 0, 16'h1234, 1'b0, 1'b0);
  endtask

  task automatic test_wait_states();
    do_fetch(16'h3001, 3, 16'hABCD, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    do_fetch(16'h4000, TO, 16'h9999, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1 || IR !== model_ir) begin
      errors++; $display("FAIL err_sticky: err=%b IR=%h required 1 %h", err, IR, model_ir);
    end
    do_fetch(16'h4001, 1, 16'h5678, 1'b0, 1'b0);
  endtask

  task automatic test_boundary();
    do_fetch(16'h4100, TO - 1, 16'hBEEF, 1'b0, 1'b0);
    do_fetch(16'h4101, TO, 16'h0BAD, 1'b0, 1'b0);
    do_fetch(16'h4102, TO - 2, 16'hC0DE, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    start = 1'b1; PCOut = 16'h2222; bus.memRdy = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    model_ir = 16'h0000; model_err = 1'b0;
    checks++;
    if (bus.memRd !== 1'b0 || busy !== 1'b0 || IR !== 16'h0 || done !== 1'b0 ||
        ldPC !== 1'b0 || bus.memAddr !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_bus: rd=%b busy=%b IR=%h done=%b ldPC=%b addr=%h required all 0",
               bus.memRd, busy, IR, done, ldPC, bus.memAddr);
    end
    bus.memRdy = 1'b1; bus.memData = 16'h7777;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || IR !== 16'h0) begin
      errors++; $display("FAIL reset_hold: done=%b IR=%h required 0 0000", done, IR);
    end
    bus.memRdy = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_fetch(16'h2223, 2, 16'h3141, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      do_fetch(16'($urandom), $urandom_range(0, 3), 16'($urandom), 1'b0, 1'b1);
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || bus.memRd !== 1'b0) begin
      errors++; $display("FAIL start_drop_idle: busy=%b rd=%b required 0 0", busy, bus.memRd);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      do_fetch(16'($urandom), $urandom_range(0, TO + 1), 16'($urandom),
               1'($urandom_range(0, 1)), 1'b0);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        bus.memRdy = 1'($urandom_range(0, 1));
        bus.memData = 16'($urandom);
        @(posedge clk); #1;
        checks++;
        if (IR !== model_ir || busy !== 1'b0 || err !== model_err) begin
          errors++;
          $display("FAIL idle_gap: IR=%h busy=%b err=%b required %h 0 %b", IR, busy, err, model_ir, model_err);
        end
      end
      bus.memRdy = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_timeout();
    test_boundary();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
